gpio_filtered_ctrl: RTL and testbench
=====================================

Name: gpio_filtered_ctrl

Overview:
Next-generation GPIO controller with a split pad interface (oe/o/i) for an external pad ring. Each pin has a configurable-depth synchroniser, a programmable debounce filter, and a five-mode interrupt detector. Sticky write-1-to-clear status feeds a masked, aggregated interrupt line to the system interrupt controller.

Parameters:
PIN_COUNT, 32, number of GPIO pins (1..64)
SYNC_STAGES, 2, synchroniser flops per pin (>=2)
DB_W, 8, width of the debounce counter and of debounce_limit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
pad_i  in  PIN_COUNT  raw pad inputs (asynchronous)
pad_o  out  PIN_COUNT  pad output values
pad_oe  out  PIN_COUNT  pad output enables, 1=drive
gpio_dir  in  PIN_COUNT  1=output, 0=input
gpio_out  in  PIN_COUNT  output data
debounce_limit  in  DB_W  stable cycles required before accepting a new level (global)
gpio_in_raw  out  PIN_COUNT  synchronised, unfiltered inputs
gpio_in  out  PIN_COUNT  debounced inputs
int_enable  in  PIN_COUNT  per-pin detector enable
int_mode  in  3*PIN_COUNT  per-pin mode, 3 bits per pin (pin i at bits 3i+2:3i)
int_clear  in  PIN_COUNT  write-1-to-clear pulse
int_mask  in  PIN_COUNT  1=pin contributes to int_out
int_status  out  PIN_COUNT  sticky status
int_out  out  1  registered OR of int_status & int_mask

Behaviour:
- Reset: all sync flops, gpio_in, debounce counters, prev-filtered flops, int_status and int_out reset to 0. pad_o and pad_oe are combinational from gpio_out/gpio_dir: pad_oe=gpio_dir, pad_o=gpio_out&gpio_dir. No reset dependency.
- Synchroniser: pad_i passes through SYNC_STAGES flops. gpio_in_raw is the last stage. Latency is SYNC_STAGES cycles.
- Debounce, per pin, counter cnt of width DB_W:
  - If raw==filtered: cnt<=0.
  - Else if cnt+1 >= debounce_limit: filtered<=raw, cnt<=0.
  - Else cnt<=cnt+1.
  - Net effect: a new level is accepted after max(debounce_limit,1) consecutive differing cycles. Limits 0 and 1 both yield a 1-cycle filter delay.
  - A raw glitch shorter than the limit leaves filtered unchanged and resets cnt.
  - No counter overflow: cnt never exceeds limit-1.
  - A change of debounce_limit mid-count takes effect on the next comparison.
- Edge detect: prev<=filtered every cycle. rise=filtered&~prev, fall=~filtered&prev.
- int_mode encoding (shared package):
  - 0 = LEVEL_LOW
  - 1 = LEVEL_HIGH
  - 2 = RISING
  - 3 = FALLING
  - 4 = BOTH
  - 5..7 = reserved; detector yields 0.
- Event: event_i = int_enable_i & mode-selected condition on filtered/rise/fall.
- Status update: int_status_i <= event_i | (int_status_i & ~int_clear_i).
  - A simultaneous event and clear leaves the status at 1; events are never lost.
  - A level mode re-asserts status every cycle while its condition holds.
  - Disabling int_enable does not clear existing status.
- int_out <= |(int_status & int_mask), a one-cycle register after status.
- Total latency from a pad edge to int_out: SYNC_STAGES + max(limit,1) + 2 cycles (status + int_out registers).
- Reset asserted mid-operation clears all state asynchronously. After release, the first filtered transitions appear only after the full sync+debounce latency. No spurious edge is flagged on release because prev=filtered=0.
- Output loopback: a pin with dir=1 still samples pad_i, so interrupts fire on driven values.

Decomposition:
- gpio_pkg: int_mode localparams (MODE_LEVEL_LOW..MODE_BOTH), MODE_W=3.
- Sub-module gpio_pin_filter: one pin's synchroniser, debounce counter, filtered/prev flops, rise/fall outputs; parameters SYNC_STAGES and DB_W.
- The top level instantiates gpio_pin_filter PIN_COUNT times in a generate loop and contains the mode decode, status register and int_out.

Test Plan:
- Reset/idle: hold rst_n=0, pad_i=all 1s → int_status=0, int_out=0, gpio_in=0. After release with limit=4, gpio_in=all 1s exactly SYNC_STAGES+4 cycles later.
- Glitch rejection: limit=5, pin0 pulses high for 4 cycles → gpio_in[0] stays 0, no RISING status. A 5-cycle pulse → gpio_in[0]=1, int_status[0]=1 one cycle after.
- BOTH mode on pin3, limit=1: toggle 0→1→0 with gaps of 10 cycles, clearing between → int_status[3] sets once per edge, twice total. int_out follows one cycle after status when int_mask[3]=1, and stays 0 when int_mask[3]=0.
- Clear/event collision: RISING on pin7, assert int_clear[7] in the same cycle a rise is detected → int_status[7] remains 1. A clear on the following cycle with no event → 0.
- LEVEL_HIGH on pin1 held high: pulse int_clear[1] → status reads 1 the next cycle (re-asserted). Drive pin low, wait for filter latency, then clear → status stays 0.
- Output/loopback and mid-op reset: dir=0xF, gpio_out=0xA → pad_oe=0xF, pad_o=0xA. Assert rst_n for 1 cycle mid-debounce → all status, counters and gpio_in return to 0, with no status set on release.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared interrupt-mode encodings and the per-pin mode decoder for the
// filtered GPIO controller.
package gpio_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_LEVEL_LOW  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LEVEL_HIGH = 3'd1;
    localparam logic [MODE_W-1:0] MODE_RISING     = 3'd2;
    localparam logic [MODE_W-1:0] MODE_FALLING    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BOTH       = 3'd4;

    // Reserved encodings (5..7) never raise an event.
    function automatic logic mode_hit(
        input logic [MODE_W-1:0] mode,
        input logic              level,
        input logic              rise,
        input logic              fall
    );
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE_LEVEL_LOW:  hit = ~level;
            MODE_LEVEL_HIGH: hit = level;
            MODE_RISING:     hit = rise;
            MODE_FALLING:    hit = fall;
            MODE_BOTH:       hit = rise | fall;
            default:         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// One pin's input path: synchroniser chain, debounce counter, and the
// filtered/previous flops that produce single-cycle rise/fall strobes.
module gpio_pin_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pad,
    input  logic [DB_W-1:0] limit,
    output logic            raw,
    output logic            filtered,
    output logic            rise,
    output logic            fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt;
    logic [DB_W:0]          cnt_inc;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    assign raw = sync_q[SYNC_STAGES-1];

    // One bit wider so the compare against an all-ones limit cannot wrap.
    assign cnt_inc = {1'b0, cnt} + (DB_W+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            filtered <= 1'b0;
            prev     <= 1'b0;
        end else begin
            prev <= filtered;
            if (raw == filtered) begin
                cnt <= '0;
            end else if (cnt_inc >= {1'b0, limit}) begin
                filtered <= raw;
                cnt      <= '0;
            end else begin
                cnt <= cnt_inc[DB_W-1:0];
            end
        end
    end

    assign rise = filtered & ~prev;
    assign fall = ~filtered & prev;

endmodule

// File: rtl/gpio_filtered_ctrl.sv
// GPIO controller: split pad interface, per-pin filtered inputs, five-mode
// interrupt detection, sticky W1C status and a masked aggregate interrupt.
module gpio_filtered_ctrl
    import gpio_pkg::*;
#(
    parameter int PIN_COUNT   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PIN_COUNT-1:0]        pad_i,
    output logic [PIN_COUNT-1:0]        pad_o,
    output logic [PIN_COUNT-1:0]        pad_oe,
    input  logic [PIN_COUNT-1:0]        gpio_dir,
    input  logic [PIN_COUNT-1:0]        gpio_out,
    input  logic [DB_W-1:0]             debounce_limit,
    output logic [PIN_COUNT-1:0]        gpio_in_raw,
    output logic [PIN_COUNT-1:0]        gpio_in,
    input  logic [PIN_COUNT-1:0]        int_enable,
    input  logic [MODE_W*PIN_COUNT-1:0] int_mode,
    input  logic [PIN_COUNT-1:0]        int_clear,
    input  logic [PIN_COUNT-1:0]        int_mask,
    output logic [PIN_COUNT-1:0]        int_status,
    output logic                        int_out
);

    logic [PIN_COUNT-1:0] rise;
    logic [PIN_COUNT-1:0] fall;
    logic [PIN_COUNT-1:0] hit;

    assign pad_oe = gpio_dir;
    assign pad_o  = gpio_out & gpio_dir;

    // Output pins keep sampling pad_i, so driven values can raise interrupts.
    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_W       (DB_W)
        ) u_filter (
            .clk     (clk),
            .rst_n   (rst_n),
            .pad     (pad_i[i]),
            .limit   (debounce_limit),
            .raw     (gpio_in_raw[i]),
            .filtered(gpio_in[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );

        assign hit[i] = int_enable[i]
                      & mode_hit(int_mode[MODE_W*i +: MODE_W], gpio_in[i], rise[i], fall[i]);
    end

    // A new event wins over a same-cycle clear, so no event is ever dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_status <= '0;
            int_out    <= 1'b0;
        end else begin
            int_status <= hit | (int_status & ~int_clear);
            int_out    <= |(int_status & int_mask);
        end
    end

endmodule

// File: tb/tb_gpio_filtered_ctrl.sv
// Bench for gpio_filtered_ctrl: directed scenarios plus randomized traffic,
// checked each cycle against a time-based reference model via a queue.
module tb_gpio_filtered_ctrl;

    localparam int N     = 32;
    localparam int SYNC  = 2;
    localparam int DB_W  = 8;
    localparam int EXP_W = 3*N + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      pad_i, pad_o, pad_oe, gpio_dir, gpio_out;
    logic [N-1:0]      gpio_in_raw, gpio_in;
    logic [N-1:0]      int_enable, int_clear, int_mask, int_status;
    logic [3*N-1:0]    int_mode;
    logic [DB_W-1:0]   debounce_limit;
    logic              int_out;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    gpio_filtered_ctrl #(
        .PIN_COUNT  (N),
        .SYNC_STAGES(SYNC),
        .DB_W       (DB_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pad_i         (pad_i),
        .pad_o         (pad_o),
        .pad_oe        (pad_oe),
        .gpio_dir      (gpio_dir),
        .gpio_out      (gpio_out),
        .debounce_limit(debounce_limit),
        .gpio_in_raw   (gpio_in_raw),
        .gpio_in       (gpio_in),
        .int_enable    (int_enable),
        .int_mode      (int_mode),
        .int_clear     (int_clear),
        .int_mask      (int_mask),
        .int_status    (int_status),
        .int_out       (int_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_vec(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Sampled pad history stands in for the synchroniser; a pin's filtered
    // level changes once the raw level has differed for max(limit,1) cycles.
    logic [N-1:0] pad_hist[$];
    logic [N-1:0] m_filt, m_prev, m_status;
    logic         m_out;
    longint       cyc;
    longint       diff_start[N];

    function automatic logic ref_hit(input int mode, input logic lvl, input logic prv);
        case (mode)
            0:       return !lvl;
            1:       return lvl;
            2:       return lvl && !prv;
            3:       return !lvl && prv;
            4:       return lvl != prv;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_filt   = '0;
        m_prev   = '0;
        m_status = '0;
        m_out    = 1'b0;
        pad_hist.delete();
        for (int p = 0; p < N; p++) diff_start[p] = -1;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic model_step();
        logic [N-1:0] raw_now, raw_after, nf, ev;
        raw_now = (pad_hist.size() == SYNC) ? pad_hist[0] : '0;
        nf = m_filt;
        ev = '0;
        for (int p = 0; p < N; p++) begin
            if (raw_now[p] == m_filt[p]) begin
                diff_start[p] = -1;
            end else begin
                if (diff_start[p] < 0) diff_start[p] = cyc;
                if (cyc - diff_start[p] + 1 >= longint'(debounce_limit)) begin
                    nf[p] = raw_now[p];
                    diff_start[p] = -1;
                end
            end
            ev[p] = int_enable[p] && ref_hit(int'(int_mode[3*p +: 3]), m_filt[p], m_prev[p]);
        end
        m_out    = |(m_status & int_mask);
        m_status = ev | (m_status & ~int_clear);
        m_prev   = m_filt;
        m_filt   = nf;
        cyc++;
        pad_hist.push_back(pad_i);
        if (pad_hist.size() > SYNC) void'(pad_hist.pop_front());
        raw_after = (pad_hist.size() == SYNC) ? pad_hist[0] : '0;
        exp_q.push_back({raw_after, m_filt, m_status, m_out});
    endtask

    initial cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_vec("gpio_in_raw", gpio_in_raw, e[2*N+1 +: N]);
            check_vec("gpio_in",     gpio_in,     e[N+1 +: N]);
            check_vec("int_status",  int_status,  e[1 +: N]);
            check_vec("int_out",     {{(N-1){1'b0}}, int_out}, {{(N-1){1'b0}}, e[0]});
        end
        check_vec("pad_oe", pad_oe, gpio_dir);
        check_vec("pad_o",  pad_o,  gpio_out & gpio_dir);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_mode(input int pin, input int mode);
        int_mode[3*pin +: 3] = 3'(mode);
    endtask

    task automatic clear_pulse(input logic [N-1:0] bits);
        int_clear = bits;
        step(1);
        int_clear = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n          = 1'b0;
        pad_i          = '1;
        gpio_dir       = '0;
        gpio_out       = '0;
        debounce_limit = 8'd4;
        int_enable     = '0;
        int_mode       = '0;
        int_clear      = '0;
        int_mask       = '1;

        // Reset/idle, then release latency with limit 4
        step(3);
        check_vec("reset_status", int_status, '0);
        check_vec("reset_out", {{(N-1){1'b0}}, int_out}, '0);
        check_vec("reset_gpio_in", gpio_in, '0);
        rst_n = 1'b1;
        step(SYNC + 4 - 1);
        check_vec("release_early", gpio_in, '0);
        step(1);
        check_vec("release_latency", gpio_in, '1);

        // Glitch rejection on pin0, limit 5
        debounce_limit = 8'd5;
        pad_i = '0;
        step(12);
        int_enable = 32'h1;
        set_mode(0, 2);
        pad_i[0] = 1'b1;
        step(4);
        pad_i[0] = 1'b0;
        step(12);
        check_vec("glitch_in", gpio_in, '0);
        check_vec("glitch_status", int_status, '0);
        pad_i[0] = 1'b1;
        step(5);
        pad_i[0] = 1'b0;
        step(2);
        check_vec("pulse_in", gpio_in, 32'h1);
        step(1);
        check_vec("pulse_status", int_status, 32'h1);
        step(10);
        clear_pulse('1);

        // BOTH mode on pin3, limit 1
        debounce_limit = 8'd1;
        int_enable = 32'h8;
        set_mode(3, 4);
        int_mask = 32'h8;
        pad_i[3] = 1'b1;
        step(4);
        check_vec("both_rise_status", int_status, 32'h8);
        check_vec("both_out_lag", {{(N-1){1'b0}}, int_out}, '0);
        step(1);
        check_vec("both_out", {{(N-1){1'b0}}, int_out}, 32'h1);
        step(5);
        clear_pulse(32'h8);
        check_vec("both_cleared", int_status, '0);
        pad_i[3] = 1'b0;
        step(10);
        check_vec("both_fall_status", int_status, 32'h8);
        int_mask = '0;
        step(2);
        check_vec("masked_out", {{(N-1){1'b0}}, int_out}, '0);
        clear_pulse(32'h8);

        // Clear/event collision on pin7
        int_mask = '1;
        int_enable = 32'h80;
        set_mode(7, 2);
        pad_i[7] = 1'b1;
        step(3);
        int_clear = 32'h80;
        step(1);
        check_vec("collision_keep", int_status, 32'h80);
        step(1);
        check_vec("clear_after", int_status, '0);
        int_clear = '0;

        // LEVEL_HIGH on pin1
        int_enable = 32'h2;
        set_mode(1, 1);
        pad_i[1] = 1'b1;
        step(6);
        check_vec("level_set", int_status, 32'h2);
        clear_pulse(32'h2);
        check_vec("level_reassert", int_status, 32'h2);
        pad_i[1] = 1'b0;
        step(5);
        clear_pulse(32'h2);
        check_vec("level_cleared", int_status, '0);

        // Pad outputs and loopback
        gpio_dir = 32'hF;
        gpio_out = 32'hA;
        #1;
        check_vec("pad_oe_dir", pad_oe, 32'hF);
        check_vec("pad_o_val", pad_o, 32'hA);
        pad_i[3:0] = 4'hA;
        step(6);
        check_vec("loopback_int", int_status & 32'h2, 32'h2);

        // Mid-debounce asynchronous reset
        clear_pulse('1);
        debounce_limit = 8'd8;
        int_enable = '1;
        for (int p = 0; p < N; p++) set_mode(p, 2);
        pad_i = '1;
        step(5);
        rst_n = 1'b0;
        #1;
        check_vec("midreset_in", gpio_in, '0);
        check_vec("midreset_status", int_status, '0);
        check_vec("midreset_out", {{(N-1){1'b0}}, int_out}, '0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check_vec("release_no_status", int_status, '0);
        check_vec("release_no_in", gpio_in, '0);

        // Randomized traffic against the model
        repeat (20) begin
            int_enable     = $urandom;
            int_mask       = $urandom;
            gpio_dir       = $urandom;
            gpio_out       = $urandom;
            debounce_limit = 8'($urandom_range(0, 6));
            for (int p = 0; p < N; p++) set_mode(p, $urandom_range(0, 7));
            repeat (40) begin
                for (int p = 0; p < N; p++)
                    if ($urandom_range(0, 9) == 0) pad_i[p] = ~pad_i[p];
                int_clear = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 29) == 0) debounce_limit = 8'($urandom_range(0, 6));
                step(1);
            end
            int_clear = '0;
            if ($urandom_range(0, 4) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
        end

        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
